div_ratio_ctrl: RTL and testbench
=================================

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 6, meaning the divide-counter width; legal ratios are 2..2^CW.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 64, meaning the ratio loaded at reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit, the run request (level).
REQ-006 The block SHALL have port cfg_valid, input, 1 bit, a new-ratio request.
REQ-007 The block SHALL have port cfg_div, input, CW+1 bits, the requested ratio N.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit, indicating the block can accept a ratio.
REQ-009 The block SHALL have port div_out, output, 1 bit, the registered divided square wave.
REQ-010 The block SHALL have port tick, output, 1 bit, a one-cycle pulse on the last cycle of each divided period.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a ratio change is pending.
REQ-012 The block SHALL have port err, output, 1 bit, a sticky illegal-ratio flag, present only with DIV_ERR_EN.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, PEND and DRAIN.
REQ-014 The counter cnt SHALL count 0..N-1 in RUN, PEND and DRAIN, wrapping to 0 after N-1, and SHALL hold 0 in IDLE.
REQ-015 tick SHALL be 1 exactly when cnt==N-1 and the state is not IDLE; div_out SHALL be registered, 0 for cnt<floor(N/2) and 1 otherwise, and 0 in IDLE.
REQ-016 For N=64 div_out SHALL equal cnt[5] delayed by one cycle.
REQ-017 Transition IDLE->RUN SHALL occur on the cycle after en=1, with cnt starting at 0.
REQ-018 Transition RUN->DRAIN SHALL occur on en=0; DRAIN SHALL complete the current period and enter IDLE on the cycle after tick.
REQ-019 If en returns to 1 during DRAIN, the FSM SHALL return to RUN with no period truncated.
REQ-020 cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND and DRAIN; a transfer occurs on cfg_valid & cfg_ready.
REQ-021 A transfer in IDLE SHALL load N on the next cycle.
REQ-022 A transfer in RUN SHALL store cfg_div in a shadow register, move to PEND and set busy.
REQ-023 PEND SHALL apply the shadow at the next terminal count: cnt goes to 0, N takes the shadow value, busy clears, and the state returns to RUN, or to DRAIN if en=0.
REQ-024 A transfer coinciding with the terminal count SHALL apply at the following boundary, never the current one.
REQ-025 The output period SHALL never be truncated or stretched by a ratio change; every divided period SHALL be exactly the old or the new N.
REQ-026 cfg_div values <2 or >2^CW SHALL be illegal.

Reset
REQ-027 rst_n=0 SHALL, at any state including mid-period or in PEND, set state=IDLE, cnt=0, N=DEFAULT_DIV, shadow=DEFAULT_DIV, div_out=0, tick=0, busy=0, cfg_ready=1 and err=0, discarding any pending change.

Configuration
REQ-028 With the macro DIV_ERR_EN defined, an illegal cfg_div SHALL be accepted-and-dropped (ratio unchanged, no PEND) and SHALL set err until reset.
REQ-029 Without DIV_ERR_EN, the err port SHALL be absent and an illegal cfg_div SHALL be clamped (<2 to 2, >2^CW to 2^CW) and applied normally.

Structure
REQ-030 The package div_pkg SHALL hold the FSM state enum and the constants MIN_DIV=2 and the defaults for CW and DEFAULT_DIV.
REQ-031 The counter, with load, wrap and terminal-count logic, SHALL be the sub-module div_counter; the FSM, handshake and shadow SHALL live in div_ratio_ctrl.

Verification
REQ-032 Reset then en=1 with the default ratio -> tick every 64 cycles, div_out low for 32 cycles and high for 32, first tick 64 cycles after RUN entry.
REQ-033 In IDLE cfg_div=10 then en=1 -> period 10, div_out 5 low / 5 high, cfg_ready stays 1.
REQ-034 In RUN (N=64) cfg_div=8 at cnt=20 -> busy=1 and cfg_ready=0 for 43 cycles, that period completes at 64, subsequent periods are 8.
REQ-035 en=0 at cnt=3 with N=16 -> 12 more cycles then tick, then IDLE with div_out=0; en=1 in DRAIN -> RUN with no gap.
REQ-036 cfg_div=1: with DIV_ERR_EN -> err=1 and ratio unchanged; without -> N=2, div_out toggles every cycle.
REQ-037 rst_n=0 during PEND -> next cycle IDLE, N=64, busy=0 and the shadow is discarded.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default parameters for the ratio divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        DRAIN
    } div_state_e;

    localparam int MIN_DIV = 2;
    localparam int DEF_CW  = 6;
    localparam int DEF_DIV = 64;

endpackage

// File: rtl/div_counter.sv
// div_counter: period counter running 0..n-1 and wrapping; held (loaded) at zero while not running.
module div_counter
    import div_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [CW:0]   n,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW:0] ONE = {{CW{1'b0}}, 1'b1};

    assign tc = run && ({1'b0, cnt} == (n - ONE));

    always_ff @(posedge clk) begin
        if (!rst_n || !run || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: programmable clock divider whose ratio changes only on period boundaries.
// Define DIV_ERR_EN to drop illegal ratios and raise a sticky err flag instead of clamping them.
module div_ratio_ctrl
    import div_pkg::*;
#(
    parameter int CW          = DEF_CW,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cfg_valid,
    input  logic [CW:0] cfg_div,
    output logic        cfg_ready,
    output logic        div_out,
    output logic        tick,
    output logic        busy
`ifdef DIV_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [CW:0] MIN_N = MIN_DIV[CW:0];
    localparam logic [CW:0] MAX_N = {1'b1, {CW{1'b0}}};
    localparam logic [CW:0] DEF_N = DEFAULT_DIV[CW:0];

    div_state_e    state_q;
    div_state_e    state_d;
    logic [CW:0]   n_q;
    logic [CW:0]   shadow_q;
    logic [CW:0]   cfg_new;
    logic [CW-1:0] cnt;
    logic          run;
    logic          tc;
    logic          xfer;
    logic          take;

    assign xfer = cfg_valid && cfg_ready;

`ifdef DIV_ERR_EN
    logic cfg_illegal;

    assign cfg_illegal = (cfg_div < MIN_N) || (cfg_div > MAX_N);
    assign take        = xfer && !cfg_illegal;
    assign cfg_new     = cfg_div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (xfer && cfg_illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign take    = xfer;
    assign cfg_new = (cfg_div < MIN_N) ? MIN_N :
                     (cfg_div > MAX_N) ? MAX_N : cfg_div;
`endif

    div_counter #(
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .n     (n_q),
        .cnt   (cnt),
        .tc    (tc)
    );

    assign tick = tc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending change is only resolved at a terminal count, so en is ignored while in PEND.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (take)     state_d = PEND;
                else if (!en) state_d = DRAIN;
            end
            PEND: begin
                if (tc) state_d = en ? RUN : DRAIN;
            end
            DRAIN: begin
                if (en)      state_d = RUN;
                else if (tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == IDLE) || (state_q == RUN);
        busy      = (state_q == PEND);
        run       = (state_q != IDLE);
    end

    // N only moves while the counter is parked in IDLE or exactly at a period boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q      <= DEF_N;
            shadow_q <= DEF_N;
            div_out  <= 1'b0;
        end else begin
            if (state_q == IDLE && take) begin
                n_q <= cfg_new;
            end else if (state_q == PEND && tc) begin
                n_q <= shadow_q;
            end
            if (state_q == RUN && take) begin
                shadow_q <= cfg_new;
            end
            div_out <= run && ({1'b0, cnt} >= (n_q >> 1));
        end
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// tb_div_ratio_ctrl: directed and randomized checking of div_ratio_ctrl against a cycle-level reference model.
module tb_div_ratio_ctrl;

    localparam int CW   = 6;
    localparam int MAXN = 1 << CW;
`ifdef DIV_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [CW:0] cfg_div = '0;
    logic        cfg_ready;
    logic        div_out;
    logic        tick;
    logic        busy;
`ifdef DIV_ERR_EN
    logic        err;
`endif

    div_ratio_ctrl #(
        .CW          (CW),
        .DEFAULT_DIV (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy)
`ifdef DIV_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;

    logic obs_tick, obs_div, obs_ready, obs_busy;

    // Reference model: an active flag, a pending ratio and a stop request, plus a phase within the period.
    bit m_valid = 1'b0;
    bit m_active, m_stop, m_pend, m_err, m_div;
    int m_n, m_pend_n, m_phase;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelStep(input logic r, input logic e, input logic v, input int d);
        bit last, xfer, legal, accepted;
        int val;
        if (!r) begin
            m_valid = 1'b1; m_active = 1'b0; m_stop = 1'b0; m_pend = 1'b0;
            m_err = 1'b0; m_div = 1'b0; m_n = 64; m_pend_n = 64; m_phase = 0;
            return;
        end
        if (!m_valid) return;
        last     = m_active && (m_phase == m_n - 1);
        xfer     = v && (!m_active || (!m_pend && !m_stop));
        legal    = (d >= 2) && (d <= MAXN);
        val      = (d < 2) ? 2 : ((d > MAXN) ? MAXN : d);
        accepted = xfer && (legal || !ERR_BUILD);
        if (xfer && !legal && ERR_BUILD) m_err = 1'b1;
        m_div = m_active && (m_phase >= m_n / 2);
        if (!m_active) begin
            if (accepted) m_n = val;
            if (e) begin
                m_active = 1'b1; m_stop = 1'b0; m_phase = 0;
            end
        end else begin
            m_phase = last ? 0 : m_phase + 1;
            if (m_pend) begin
                if (last) begin
                    m_n = m_pend_n; m_pend = 1'b0; m_stop = !e;
                end
            end else if (m_stop) begin
                if (e)         m_stop = 1'b0;
                else if (last) m_active = 1'b0;
            end else if (accepted) begin
                m_pend = 1'b1; m_pend_n = val;
            end else if (!e) begin
                m_stop = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic v, input int d);
        @(negedge clk);
        rst_n = r; en = e; cfg_valid = v; cfg_div = d[CW:0];
        #1;
        obs_tick = tick; obs_div = div_out; obs_ready = cfg_ready; obs_busy = busy;
        if (m_valid) begin
            checkOutput("tick", obs_tick, m_active && (m_phase == m_n - 1));
            checkOutput("div_out", obs_div, m_div);
            checkOutput("cfg_ready", obs_ready, !m_active || (!m_pend && !m_stop));
            checkOutput("busy", obs_busy, m_pend);
`ifdef DIV_ERR_EN
            checkOutput("err", err, m_err);
`endif
        end
        @(posedge clk);
        modelStep(r, e, v, d);
        cyc++;
    endtask

    initial begin
        int   ticks[$];
        int   cnt_a, cnt_b, toggles;
        logic prev_div, ready_snap, cur_en, r, v;
        int   d;

        $display("[TB] starting div_ratio_ctrl checks");

        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_ready", obs_ready, 1);
        checkOutput("rst_busy", obs_busy, 0);
        checkOutput("rst_tick", obs_tick, 0);
        checkOutput("rst_div", obs_div, 0);

        // Default ratio: 64-cycle period, 32 low / 32 high.
        applyStimulus(1, 1, 0, 0);
        ticks.delete(); cnt_a = 0;
        for (int i = 1; i <= 130; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (obs_tick) ticks.push_back(i);
            if (i >= 2 && i <= 65 && obs_div) cnt_a++;
        end
        checkOutput("a_tick_count", ticks.size(), 2);
        checkOutput("a_first_tick", (ticks.size() > 0) ? ticks[0] : -1, 64);
        checkOutput("a_period", (ticks.size() > 1) ? ticks[1] - ticks[0] : -1, 64);
        checkOutput("a_high_cycles", cnt_a, 32);

        // Ratio 10 loaded in IDLE.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 10);
        applyStimulus(1, 1, 0, 0);
        ticks.delete(); cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (obs_tick) ticks.push_back(i);
            if (i >= 2 && i <= 11 && obs_div) cnt_a++;
            if (!obs_ready) cnt_b++;
        end
        checkOutput("b_tick_count", ticks.size(), 4);
        checkOutput("b_first_tick", (ticks.size() > 0) ? ticks[0] : -1, 10);
        checkOutput("b_period", (ticks.size() > 1) ? ticks[1] - ticks[0] : -1, 10);
        checkOutput("b_high_cycles", cnt_a, 5);
        checkOutput("b_ready_low", cnt_b, 0);

        // Ratio 8 requested at cnt=20 while running at 64.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 8);
        ticks.delete(); cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (obs_tick) ticks.push_back(i);
            if (obs_busy) cnt_a++;
            if (!obs_ready) cnt_b++;
        end
        checkOutput("c_busy_cycles", cnt_a, 43);
        checkOutput("c_ready_low", cnt_b, 43);
        checkOutput("c_old_period_end", (ticks.size() > 0) ? ticks[0] : -1, 43);
        checkOutput("c_new_period1", (ticks.size() > 1) ? ticks[1] - ticks[0] : -1, 8);
        checkOutput("c_new_period2", (ticks.size() > 2) ? ticks[2] - ticks[1] : -1, 8);

        // Drain with N=16: en drops at cnt=3.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 16);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        ticks.delete(); cnt_a = 0; ready_snap = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (obs_tick) ticks.push_back(i);
            if (i == 13) ready_snap = obs_ready;
            if (i >= 14 && obs_div) cnt_a++;
        end
        checkOutput("d_tick_count", ticks.size(), 1);
        checkOutput("d_drain_tick", (ticks.size() > 0) ? ticks[0] : -1, 12);
        checkOutput("d_idle_ready", ready_snap, 1);
        checkOutput("d_idle_div_high", cnt_a, 0);

        // Drain interrupted by en=1 resumes without a gap.
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        ticks.delete(); ready_snap = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (obs_tick) ticks.push_back(i);
            if (i == 2) ready_snap = obs_ready;
        end
        checkOutput("d_resume_tick", (ticks.size() > 0) ? ticks[0] : -1, 10);
        checkOutput("d_resume_period", (ticks.size() > 1) ? ticks[1] - ticks[0] : -1, 16);
        checkOutput("d_resume_ready", ready_snap, 1);

        // Illegal ratio 1: clamped to 2, or dropped with err.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0);
        cnt_a = 0; toggles = 0; prev_div = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (obs_tick) cnt_a++;
            if (i >= 3 && obs_div != prev_div) toggles++;
            prev_div = obs_div;
        end
        checkOutput("e_ticks", cnt_a, ERR_BUILD ? 0 : 6);
        checkOutput("e_toggles", toggles, ERR_BUILD ? 0 : 10);
`ifdef DIV_ERR_EN
        checkOutput("e_err", err, 1);
`endif

        // Reset while a change is pending discards the shadow.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 8);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);
        checkOutput("f_busy_before", obs_busy, 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("f_busy_after", obs_busy, 0);
        checkOutput("f_ready_after", obs_ready, 1);
        ticks.delete();
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (obs_tick) ticks.push_back(i);
        end
        checkOutput("f_first_tick", (ticks.size() > 0) ? ticks[0] : -1, 64);

        // Randomized traffic against the model.
        applyStimulus(0, 0, 0, 0);
        cur_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (cur_en && $urandom_range(0, 39) == 0) cur_en = 1'b0;
            else if (!cur_en && $urandom_range(0, 9) == 0) cur_en = 1'b1;
            r = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 14) == 0);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 20));
            applyStimulus(r, cur_en, v, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
